// File: rtl/ahb_wb_pkg.sv
// Shared definitions for the AHB-Lite to Wishbone bridge: transfer encodings
// and the bridge FSM state type.
package ahb_wb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP,
        ST_ERR1,
        ST_ERR2
    } state_t;

endpackage

// File: rtl/ahb_wb_sel_gen.sv
// Byte-lane decode and alignment check for one AHB transfer (little-endian).
module ahb_wb_sel_gen #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]                      hsize,
    input  logic [$clog2(DATA_WIDTH/8)-1:0] addr_lsb,
    output logic [DATA_WIDTH/8-1:0]         sel,
    output logic                            illegal
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned LSB_W = $clog2(NB);

    int unsigned       bytes;
    logic [LSB_W-1:0]  align_mask;
    logic [NB-1:0]     lanes;

    always_comb begin
        bytes      = 32'd1 << hsize;
        align_mask = LSB_W'(bytes - 32'd1);
        lanes      = NB'((32'd1 << bytes) - 32'd1);
        illegal    = (32'(hsize) > LSB_W) || ((addr_lsb & align_mask) != '0);
        sel        = illegal ? '0 : (lanes << addr_lsb);
    end

endmodule

// File: rtl/ahb_wb_bridge.sv
// AHB-Lite slave to Wishbone classic master bridge, one outstanding transfer,
// two-cycle ERROR response for illegal transfers, bus errors and ack timeouts.
module ahb_wb_bridge
    import ahb_wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    HSEL,
    input  logic [ADDR_WIDTH-1:0]   HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [DATA_WIDTH-1:0]   HWDATA,
    input  logic                    HREADY,
    output logic [DATA_WIDTH-1:0]   HRDATA,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    output logic                    wb_cyc,
    output logic                    wb_stb,
    output logic                    wb_we,
    output logic [ADDR_WIDTH-1:0]   wb_adr,
    output logic [DATA_WIDTH/8-1:0] wb_sel,
    output logic [DATA_WIDTH-1:0]   wb_dat_w,
    input  logic [DATA_WIDTH-1:0]   wb_dat_r,
    input  logic                    wb_ack,
    input  logic                    wb_err
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int LSB_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   adr_r;
    logic                    we_r;
    logic [NB-1:0]           sel_r;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_WIDTH-1:0]   rdata_r;
    logic [NB-1:0]           sel_dec;
    logic                    illegal;
    logic                    accept;
    logic                    in_bus;
    logic                    timeout_hit;

    ahb_wb_sel_gen #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_sel_gen (
        .hsize    (HSIZE),
        .addr_lsb (HADDR[LSB_W-1:0]),
        .sel      (sel_dec),
        .illegal  (illegal)
    );

    assign in_bus      = (state == ST_BUS);
    assign accept      = ((state == ST_IDLE) || (state == ST_RESP) || (state == ST_ERR2)) &&
                         HSEL && HREADY &&
                         ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

    assign wb_we    = in_bus & we_r;
    assign wb_sel   = in_bus ? sel_r : '0;
    assign wb_adr   = adr_r;
    assign wb_dat_w = HWDATA;
    assign HRDATA   = rdata_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        wb_cyc    = 1'b0;
        wb_stb    = 1'b0;
        case (state)
            ST_IDLE, ST_RESP, ST_ERR2: begin
                HRESP = (state == ST_ERR2);
                if (accept) state_nxt = illegal ? ST_ERR1 : ST_BUS;
                else        state_nxt = ST_IDLE;
            end
            ST_BUS: begin
                HREADYOUT = 1'b0;
                wb_cyc    = 1'b1;
                wb_stb    = 1'b1;
                // err has priority over ack; ack on the last allowed cycle still completes
                if (wb_err)           state_nxt = ST_ERR1;
                else if (wb_ack)      state_nxt = ST_RESP;
                else if (timeout_hit) state_nxt = ST_ERR1;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_nxt = ST_ERR2;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Lanes are decoded at acceptance and held, so only the select is stored, not HSIZE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adr_r   <= '0;
            we_r    <= 1'b0;
            sel_r   <= '0;
            cnt     <= '0;
            rdata_r <= '0;
        end else begin
            if (accept) begin
                adr_r <= HADDR;
                we_r  <= HWRITE;
                sel_r <= sel_dec;
            end
            if (in_bus && wb_ack && !wb_err && !we_r) rdata_r <= wb_dat_r;
            cnt <= in_bus ? cnt + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_ahb_wb_bridge.sv
// Directed bench for ahb_wb_bridge: scoreboard of expected AHB responses
// checked by a completion monitor, plus direct Wishbone-side checks.
module tb_ahb_wb_bridge;
    import ahb_wb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           HSEL;
    logic [AW-1:0]  HADDR;
    logic [1:0]     HTRANS;
    logic           HWRITE;
    logic [2:0]     HSIZE;
    logic [DW-1:0]  HWDATA;
    logic           HREADY;
    logic [DW-1:0]  HRDATA;
    logic           HREADYOUT;
    logic           HRESP;
    logic           wb_cyc, wb_stb, wb_we;
    logic [AW-1:0]  wb_adr;
    logic [3:0]     wb_sel;
    logic [DW-1:0]  wb_dat_w, wb_dat_r;
    logic           wb_ack, wb_err;

    always #5 clk = ~clk;
    assign HREADY = HREADYOUT;

    ahb_wb_bridge #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_sel(wb_sel), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r),
        .wb_ack(wb_ack), .wb_err(wb_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc_cyc, first_acc, n0;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: responds ack_delay cycles after stb rises; read data depends on address
    logic          ack_en, err_en;
    int            ack_delay;
    int            wcnt = 0;
    logic [DW-1:0] slave_data;

    always @(posedge clk) begin
        if (!wb_stb || wb_ack || wb_err) wcnt <= 0;
        else                             wcnt <= wcnt + 1;
    end
    assign wb_ack   = wb_stb && ack_en && (wcnt == ack_delay);
    assign wb_err   = wb_stb && err_en && (wcnt == ack_delay);
    assign wb_dat_r = slave_data ^ wb_adr;

    typedef struct packed {
        logic          resp;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [DW-1:0] model_rd;
    logic          dphase   = 1'b0;
    logic          prev_ack = 1'b0;
    int            n_done   = 0;
    int            last_done = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Completion monitor: a data phase ends in the cycle HREADYOUT is high
    always @(negedge clk) begin
        if (rst) begin
            dphase   = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (dphase && HREADYOUT) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL sb_underflow: observed completion with HRESP=%0b expected none", HRESP);
                end else begin
                    mon_e = sb.pop_front();
                    chk("hresp", {63'd0, HRESP}, {63'd0, mon_e.resp});
                    chk("hrdata", {32'd0, HRDATA}, {32'd0, mon_e.data});
                    if (!mon_e.resp) chk("ack_before_ready", {63'd0, prev_ack}, 64'd1);
                    n_done++;
                    last_done = cyc;
                end
            end
            if (HSEL && HREADY && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ)))
                dphase = 1'b1;
            else if (HREADY)
                dphase = 1'b0;
            prev_ack = wb_ack;
        end
    end

    task automatic issue(input logic [AW-1:0] a, input logic w, input logic [2:0] sz,
                         input logic [DW-1:0] wd, input logic exp_resp);
        int n;
        HSEL   = 1'b1;
        HADDR  = a;
        HTRANS = HTRANS_NONSEQ;
        HWRITE = w;
        HSIZE  = sz;
        n = 0;
        @(negedge clk);
        while (!HREADY && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", {63'd0, HREADY}, 64'd1);
        acc_cyc = cyc;
        if (!exp_resp && !w) model_rd = slave_data ^ a;
        sb.push_back({exp_resp, model_rd});
        @(posedge clk);
        #1;
        HTRANS = HTRANS_IDLE;
        HWDATA = wd;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((dphase || sb.size() != 0) && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_wb(input logic [AW-1:0] a, input logic [3:0] s, input logic w,
                            input logic [DW-1:0] d);
        #1;
        chk("wb_cyc", {63'd0, wb_cyc}, 64'd1);
        chk("wb_stb", {63'd0, wb_stb}, 64'd1);
        chk("wb_adr", {32'd0, wb_adr}, {32'd0, a});
        chk("wb_sel", {60'd0, wb_sel}, {60'd0, s});
        chk("wb_we", {63'd0, wb_we}, {63'd0, w});
        chk("wb_dat_w", {32'd0, wb_dat_w}, {32'd0, d});
        chk("bus_hreadyout", {63'd0, HREADYOUT}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
        HSIZE = HSIZE_WORD; HWDATA = '0;
        ack_en = 1'b1; err_en = 1'b0; ack_delay = 0; slave_data = '0; model_rd = '0;
        #1;
        chk("rst_hreadyout", {63'd0, HREADYOUT}, 64'd1);
        chk("rst_hresp", {63'd0, HRESP}, 64'd0);
        chk("rst_wb_cyc", {63'd0, wb_cyc}, 64'd0);
        chk("rst_wb_stb", {63'd0, wb_stb}, 64'd0);
        chk("rst_wb_we", {63'd0, wb_we}, 64'd0);
        chk("rst_wb_adr", {32'd0, wb_adr}, 64'd0);
        chk("rst_wb_sel", {60'd0, wb_sel}, 64'd0);
        chk("rst_hrdata", {32'd0, HRDATA}, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // BUSY with HSEL: zero-wait OKAY, no bus cycle
        HSEL = 1'b1; HTRANS = HTRANS_BUSY;
        repeat (2) begin
            @(negedge clk);
            chk("busy_hreadyout", {63'd0, HREADYOUT}, 64'd1);
            chk("busy_hresp", {63'd0, HRESP}, 64'd0);
            chk("busy_wb_cyc", {63'd0, wb_cyc}, 64'd0);
        end
        @(posedge clk); #1;
        HTRANS = HTRANS_IDLE;

        // Word read, slave acks two cycles after stb
        ack_delay = 2; slave_data = 32'hDEADBEEF ^ 32'h0000_1000;
        issue(32'h0000_1000, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
        check_wb(32'h0000_1000, 4'b1111, 1'b0, 32'h0);
        wait_done();
        chk("read_deadbeef", {32'd0, HRDATA}, 64'hDEADBEEF);

        // Byte / halfword writes and a byte read, zero-wait slave
        ack_delay = 0; slave_data = 32'h1122_3344;
        issue(32'h203, 1'b1, HSIZE_BYTE, 32'hAABBCCDD, 1'b0);
        check_wb(32'h203, 4'b1000, 1'b1, 32'hAABBCCDD);
        wait_done();
        issue(32'h102, 1'b1, HSIZE_HALF, 32'h5566_7788, 1'b0);
        check_wb(32'h102, 4'b1100, 1'b1, 32'h5566_7788);
        wait_done();
        issue(32'h201, 1'b0, HSIZE_BYTE, 32'h0, 1'b0);
        check_wb(32'h201, 4'b0010, 1'b0, 32'h0);
        wait_done();

        // Misaligned halfword: two-cycle ERROR, no Wishbone cycle
        issue(32'h101, 1'b0, HSIZE_HALF, 32'h0, 1'b1);
        #1;
        chk("err1_wb_cyc", {63'd0, wb_cyc}, 64'd0);
        chk("err1_hreadyout", {63'd0, HREADYOUT}, 64'd0);
        chk("err1_hresp", {63'd0, HRESP}, 64'd1);
        @(posedge clk); #1;
        chk("err2_hreadyout", {63'd0, HREADYOUT}, 64'd1);
        chk("err2_hresp", {63'd0, HRESP}, 64'd1);
        chk("err2_wb_cyc", {63'd0, wb_cyc}, 64'd0);
        wait_done();

        // Oversize (doubleword on 32-bit bus) and misaligned word
        issue(32'h0, 1'b0, HSIZE_DWORD, 32'h0, 1'b1);
        #1 chk("dword_wb_cyc", {63'd0, wb_cyc}, 64'd0);
        wait_done();
        issue(32'h202, 1'b1, HSIZE_WORD, 32'h0, 1'b1);
        #1 chk("misalign_wb_cyc", {63'd0, wb_cyc}, 64'd0);
        wait_done();

        // ack and err together: err wins, HRDATA untouched
        err_en = 1'b1; ack_delay = 1;
        issue(32'h300, 1'b0, HSIZE_WORD, 32'h0, 1'b1);
        wait_done();
        err_en = 1'b0;

        // Timeout: slave never acks, cyc held for exactly TO cycles
        ack_en = 1'b0;
        issue(32'h400, 1'b0, HSIZE_WORD, 32'h0, 1'b1);
        for (int i = 0; i < TO; i++) begin
            chk("to_wb_cyc_held", {63'd0, wb_cyc}, 64'd1);
            @(posedge clk); #1;
        end
        chk("to_wb_cyc_drop", {63'd0, wb_cyc}, 64'd0);
        chk("to_hresp", {63'd0, HRESP}, 64'd1);
        chk("to_hreadyout", {63'd0, HREADYOUT}, 64'd0);
        wait_done();
        ack_en = 1'b1;

        // Four back-to-back reads to a zero-wait slave
        ack_delay = 0; slave_data = 32'hCAFE_0000;
        n0 = n_done;
        issue(32'h500, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
        first_acc = acc_cyc;
        issue(32'h504, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
        issue(32'h508, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
        issue(32'h50C, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
        wait_done();
        chk("b2b_count", 64'(n_done - n0), 64'd4);
        chk("b2b_cycles", 64'(last_done - first_acc), 64'd8);

        // Reset mid-transfer: bus drops immediately, no late response
        ack_en = 1'b0;
        issue(32'h600, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
        #1 chk("pre_rst_wb_cyc", {63'd0, wb_cyc}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_wb_cyc", {63'd0, wb_cyc}, 64'd0);
        chk("rst_mid_wb_stb", {63'd0, wb_stb}, 64'd0);
        chk("rst_mid_hreadyout", {63'd0, HREADYOUT}, 64'd1);
        chk("rst_mid_hrdata", {32'd0, HRDATA}, 64'd0);
        sb.delete();
        model_rd = '0;
        @(posedge clk); #1;
        rst = 1'b0; ack_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ack_delay = 1; slave_data = 32'h0BAD_F00D;
        issue(32'h700, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
        wait_done();
        chk("post_rst_read", {32'd0, HRDATA}, {32'd0, 32'h0BAD_F00D ^ 32'h700});

        repeat (2) @(posedge clk);
        chk("sb_empty_end", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_wb_bridge.md
AHB_WB_BRIDGE -- requirements
Module: ahb_wb_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width of HADDR and wb_adr.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; legal values are 32 and 64.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, Wishbone ack timeout in cycles; 0 disables the timeout.
REQ-004 SHALL have port clk  in  1  the single clock; everything is sampled on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have AHB-Lite slave inputs: HSEL 1, HADDR ADDR_WIDTH, HTRANS 2, HWRITE 1, HSIZE 3, HWDATA DATA_WIDTH, HREADY 1.
REQ-007 SHALL have AHB-Lite slave outputs: HRDATA DATA_WIDTH, HREADYOUT 1, HRESP 1.
REQ-008 SHALL have Wishbone classic master outputs: wb_cyc 1, wb_stb 1, wb_we 1, wb_adr ADDR_WIDTH (byte address), wb_sel DATA_WIDTH/8, wb_dat_w DATA_WIDTH.
REQ-009 SHALL have Wishbone inputs: wb_dat_r DATA_WIDTH, wb_ack 1, wb_err 1.

Function
REQ-010 SHALL accept an address phase when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ; IDLE and BUSY transfers get a zero-wait OKAY response.
REQ-011 SHALL implement the FSM states IDLE, BUS, RESP, ERR1 and ERR2.
REQ-012 SHALL register HADDR, HWRITE and HSIZE on an accepted phase and move to BUS on the next cycle, or to ERR1 if the transfer is illegal.
REQ-013 SHALL treat a transfer as illegal when HSIZE exceeds log2(DATA_WIDTH/8) or when HADDR is not aligned to HSIZE; an illegal transfer starts no Wishbone cycle.
REQ-014 In BUS, SHALL drive wb_cyc=wb_stb=1, HREADYOUT=0, wb_we and wb_adr from registers, and wb_dat_w=HWDATA (pass-through, held stable by the master).
REQ-015 SHALL decode wb_sel from the registered HSIZE and low address bits: a byte, halfword, word or doubleword enables the corresponding contiguous lanes, little-endian.
REQ-016 When wb_ack=1 in BUS, SHALL capture wb_dat_r into the HRDATA register, deassert wb_cyc/wb_stb the next cycle, and move to RESP.
REQ-017 In RESP, SHALL drive HREADYOUT=1 and HRESP=0 for exactly one cycle, then move to BUS/ERR1 if a new phase is accepted in that cycle, else to IDLE.
REQ-018 When wb_err=1 in BUS, SHALL move to ERR1; if wb_ack and wb_err are both 1, wb_err wins.
REQ-019 In BUS, SHALL count cycles; when the count reaches TIMEOUT_CYCLES without ack or err, SHALL drop wb_cyc/wb_stb and move to ERR1.
REQ-020 In ERR1, SHALL drive HREADYOUT=0 and HRESP=1; in ERR2, HREADYOUT=1 and HRESP=1; ERR2 accepts a new phase exactly as RESP does.
REQ-021 In IDLE, SHALL drive HREADYOUT=1 and HRESP=0.
REQ-022 For a zero-wait Wishbone slave, SHALL sustain one transfer every 2 cycles: address phase at N, wb_stb at N+1, HREADYOUT=1 at N+2.
REQ-023 SHALL keep HRDATA at its last captured value except when a read completes.

Reset
REQ-024 On rst=1, SHALL immediately reach: state IDLE, wb_cyc=wb_stb=wb_we=0, wb_adr=0, wb_sel=0, HRDATA=0, HREADYOUT=1, HRESP=0, timeout counter=0.
REQ-025 A reset asserted mid-transfer SHALL abandon that transfer, dropping wb_cyc in the same cycle, with no response generated after reset is released.

Structure
REQ-026 SHALL take from shared package ahb_wb_pkg: the HTRANS encodings, the HSIZE constants, and the FSM state enum type.
REQ-027 SHALL place lane decoding and alignment checking in a combinational sub-module ahb_wb_sel_gen (inputs: HSIZE and address LSBs; outputs: sel and illegal).
REQ-028 SHALL size the timeout counter as $clog2(TIMEOUT_CYCLES+1) bits.

Verification
REQ-029 Word read at 0x0000_1000; slave acks 2 cycles after wb_stb with 0xDEADBEEF -> HRDATA=0xDEADBEEF, HREADYOUT=1 one cycle after ack, HRESP=0.
REQ-030 Byte write at HADDR=0x203 with HWDATA=0xAABBCCDD -> wb_adr=0x203, wb_sel=4'b1000, wb_we=1, wb_dat_w=0xAABBCCDD.
REQ-031 Halfword read at HADDR=0x101 -> wb_cyc never asserted; HRESP=1 for 2 cycles, with HREADYOUT 0 then 1.
REQ-032 TIMEOUT_CYCLES=4 and a slave that never acks -> wb_cyc drops after 4 BUS cycles, followed by the 2-cycle ERROR response.
REQ-033 Four back-to-back NONSEQ reads to a zero-wait slave -> 4 completions in 8 cycles, each new phase accepted in a RESP cycle.
REQ-034 rst pulsed while wb_cyc=1 -> wb_cyc=wb_stb=0 and HREADYOUT=1 in the same cycle; a subsequent read completes normally.
